// File: rtl/gs_rx_pkg.sv
// Shared types and constants for the 129-tap symmetric receive FIR sequencing logic.
package gs_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } gs_rx_state_t;

    localparam int GS_RX_TAPS        = 129;
    localparam int GS_RX_UNIQUE_COEF = 65;

endpackage

// File: rtl/gs_rx_filter_ctrl_if.sv
// Control/status bundle between the upstream sequencer master and the FIR controller.
interface gs_rx_filter_ctrl_if;
    import gs_rx_pkg::*;

    logic         start;
    logic         stop;
    logic         sample_valid_in;
    logic         clk_en;
    logic         zero_in;
    logic         y_valid;
    logic         busy;
    logic         done;
    logic         overrun;
    gs_rx_state_t state;

    modport master (
        output start, stop, sample_valid_in,
        input  clk_en, zero_in, y_valid, busy, done, overrun, state
    );

    modport slave (
        input  start, stop, sample_valid_in,
        output clk_en, zero_in, y_valid, busy, done, overrun, state
    );

endinterface

// File: rtl/gs_strobe_div.sv
// Free-running strobe generator: one-cycle tick every DIV clocks while en is high,
// phase restarted whenever en is low so the first tick lands DIV clocks after en rises.
module gs_strobe_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divide counter and registered tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (!en) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == CW'(DIV - 1)) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/gs_rx_filter_ctrl.sv
// Sequencing controller for the receive FIR: gates clk_en from sample strobes, tracks
// delay-line fill, decimates the output-valid flag and flushes the tail with zero samples.
module gs_rx_filter_ctrl
    import gs_rx_pkg::*;
#(
    parameter int TAPS      = GS_RX_TAPS,
    parameter int FILL_LEN  = TAPS + 1,
    parameter int DECIM     = 4,
    parameter int FLUSH_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    gs_rx_filter_ctrl_if.slave bus
);

    localparam int CNT_W  = $clog2(FILL_LEN + 1);
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    gs_rx_state_t      state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DCNT_W-1:0] dcnt_r;
    logic              zero_in_r;
    logic              y_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              overrun_r;

    logic              flush_en_s;
    logic              flush_tick_s;
    logic              clk_en_s;
    logic [DCNT_W-1:0] dcnt_next_s;

    assign flush_en_s  = (state_r == ST_FLUSH);
    assign dcnt_next_s = (dcnt_r == DCNT_W'(DECIM - 1)) ? '0 : dcnt_r + DCNT_W'(1);

    gs_strobe_div #(
        .DIV (FLUSH_DIV)
    ) u_flush_div (
        .clk   (clk),
        .reset (reset),
        .en    (flush_en_s),
        .tick  (flush_tick_s)
    );

    // Filter enable: same-cycle pass-through of the sample strobe, or the flush tick
    always_comb begin
        clk_en_s = 1'b0;
        case (state_r)
            ST_FILL, ST_RUN: clk_en_s = bus.sample_valid_in;
            ST_FLUSH:        clk_en_s = flush_tick_s;
            default:         clk_en_s = 1'b0;
        endcase
    end

    // Controller FSM with fill/flush counter, decimation counter and registered flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            dcnt_r    <= '0;
            zero_in_r <= 1'b0;
            y_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            y_valid_r <= 1'b0;
            done_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // stop wins over a simultaneous start; a sample offered with start is refused
                    if (bus.start && !bus.stop) begin
                        state_r   <= ST_FILL;
                        busy_r    <= 1'b1;
                        cnt_r     <= '0;
                        dcnt_r    <= '0;
                        overrun_r <= bus.sample_valid_in;
                    end else if (bus.start && bus.sample_valid_in) begin
                        overrun_r <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (bus.stop) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (bus.sample_valid_in) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(FILL_LEN - 1)) begin
                            state_r   <= ST_RUN;
                            y_valid_r <= 1'b1;
                            dcnt_r    <= DCNT_W'(1 % DECIM);
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.sample_valid_in) begin
                        y_valid_r <= (dcnt_r == '0);
                        dcnt_r    <= dcnt_next_s;
                    end
                    if (bus.stop) begin
                        state_r   <= ST_FLUSH;
                        zero_in_r <= 1'b1;
                        cnt_r     <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (bus.sample_valid_in) begin
                        overrun_r <= 1'b1;
                    end
                    if (flush_tick_s) begin
                        y_valid_r <= (dcnt_r == '0);
                        dcnt_r    <= dcnt_next_s;
                        cnt_r     <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(TAPS - 1)) begin
                            state_r   <= ST_IDLE;
                            zero_in_r <= 1'b0;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    zero_in_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clk_en  = clk_en_s;
    assign bus.zero_in = zero_in_r;
    assign bus.y_valid = y_valid_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.overrun = overrun_r;
    assign bus.state   = state_r;

endmodule

// File: doc/gs_rx_filter_ctrl.md
# gs_rx_filter_ctrl

Sequencing controller for the 129-tap symmetric receive FIR. It sits between the upstream sample source and the filter. It gates the filter's `clk_en` from the input sample strobe and tracks delay-line fill so that only outputs computed from a full window are flagged valid. It decimates the valid flag and, on stop, flushes the delay line with self-timed zero samples so the filter tail is emitted.

## Interface
- `TAPS`, 129: filter delay-line length.
- `FILL_LEN`, 130: strobes from start until `y` holds the first full-window result (`TAPS`+1, the output register adds one).
- `DECIM`, 4: output decimation factor, ≥1.
- `FLUSH_DIV`, 4: clocks per self-generated strobe during flush, ≥2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin filtering.
- `stop`  in  1  single-cycle request to end filtering.
- `sample_valid_in`  in  1  upstream strobe; `x_in` at the filter is valid this cycle.
- `clk_en`  out  1  filter enable, one cycle per sample.
- `zero_in`  out  1  forces the filter input mux to 0 (flush).
- `y_valid`  out  1  one-cycle pulse; the filter `y` register holds a decimated, full-window output.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse on return to IDLE after flush.
- `overrun`  out  1  sticky flag: a sample arrived while the controller could not accept it.
- `state`  out  2  current state encoding, for debug.

## Operation
- States: IDLE(0), FILL(1), RUN(2), FLUSH(3).
- IDLE:
  - `clk_en`=0, so the filter holds.
  - `start` → FILL. On that edge, clear the fill counter, the decimation counter `dcnt` and `overrun`.
  - If `start` and `stop` arrive in the same cycle, `stop` wins and the controller stays IDLE.
- FILL:
  - `clk_en` = `sample_valid_in`.
  - Each strobe increments the fill counter. On strobe number `FILL_LEN`: go to RUN, pulse `y_valid`, set `dcnt`=1 (mod `DECIM`).
  - `stop` → IDLE next cycle. No flush, no `done`, no `y_valid`.
- RUN:
  - `clk_en` = `sample_valid_in`.
  - On each strobe, `y_valid` pulses if `dcnt`==0, and `dcnt` advances modulo `DECIM`.
  - `stop` → FLUSH. A strobe coinconciding with `stop` is still honoured.
- FLUSH:
  - `zero_in`=1.
  - `clk_en` comes from an internal tick every `FLUSH_DIV` clocks. The first tick is `FLUSH_DIV` clocks after entry.
  - Decimation continues unchanged.
  - After `TAPS` ticks: go to IDLE, pulse `done`, deassert `zero_in`.
  - `start` is ignored.
  - Any `sample_valid_in` here is dropped and sets `overrun`.
- Overrun is also set by `sample_valid_in` in IDLE while `start` is asserted. That sample is not taken.
- Counter width: $clog2(FILL_LEN+1). `dcnt` width: $clog2(DECIM), minimum 1. No counter wraps except `dcnt`.
- Reset mid-operation: immediately drives state IDLE and all outputs 0, and clears all counters.

## Timing
- Reset values: `clk_en`=0, `zero_in`=0, `y_valid`=0, `busy`=0, `done`=0, `overrun`=0, `state`=0.
- `clk_en` is combinational from the registered state and `sample_valid_in` (or the flush tick), so it is aligned with the sample's own cycle. Zero added latency.
- `zero_in` is registered and tracks FLUSH exactly. It is 1 in the first FLUSH cycle.
- `y_valid` is registered and asserts the cycle after the qualifying strobe, which is when `y` has updated. It lasts one cycle.
- `done` asserts in the first IDLE cycle after flush.
- `state`, `busy`, `overrun` are registered.
- Back-to-back `sample_valid_in` (every cycle) must be supported in FILL/RUN.

## Structure
- Package `gs_rx_pkg`:
  - state enum `gs_rx_state_t` (2 bits, values above);
  - constants `GS_RX_TAPS`=129 and `GS_RX_UNIQUE_COEF`=65.
- One sub-module: `gs_strobe_div` (parameter `DIV`; inputs `clk`, `reset`, `en`; output one-cycle `tick` every `DIV` clocks while `en`; restarts when `en` rises). It is used for flush pacing.
- Rest is a single FSM plus counters.

## Test plan
All scenarios use the defaults (`TAPS`=129, `FILL_LEN`=130, `DECIM`=4, `FLUSH_DIV`=4).

1. Reset:
   - Stimulus: hold `reset`=0 for 5 cycles with random inputs.
   - Required: all outputs 0; `state`=0 throughout and 1 cycle after release.
2. Fill and decimation:
   - Stimulus: `start`, then `sample_valid_in` every 3rd cycle.
   - Required: `clk_en` mirrors the strobes. The first `y_valid` comes 1 cycle after strobe 130, then after strobes 134, 138, 142. `state`=2 after strobe 130.
3. Flush:
   - Stimulus: `stop` in RUN at strobe 200.
   - Required: `zero_in`=1 the next cycle. Exactly 129 `clk_en` pulses follow, 4 cycles apart. `y_valid` continues every 4th strobe. `done` pulses once, then `busy`=0.
4. Abort in fill:
   - Stimulus: `stop` after 50 FILL strobes.
   - Required: IDLE next cycle, no `y_valid`, no `done`, `zero_in` never 1.
5. Overrun:
   - Stimulus: `sample_valid_in` pulses 3 times during FLUSH.
   - Required: `clk_en` only on flush ticks, `overrun`=1 sticky through IDLE. Cleared on the next `start`.
6. Reset mid-RUN plus simultaneous start/stop:
   - Stimulus: assert `reset` at RUN strobe 150; after release, assert `start` and `stop` together.
   - Required: outputs 0 asynchronously. The controller stays IDLE with `busy`=0.
